// File: rtl/reg_unloader_if.sv
// Snapshot request and narrow beat stream between a wide register
// and its host-facing consumer.
interface reg_unloader_if #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 32
);
  logic             snap_req;
  logic [WIDTH-1:0] snap_data;
  logic             snap_ack;
  logic             busy;
  logic             out_valid;
  logic [CHUNK-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  modport master (
    output snap_req,
    output snap_data,
    output out_ready,
    input  snap_ack,
    input  busy,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  snap_req,
    input  snap_data,
    input  out_ready,
    output snap_ack,
    output busy,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/reg_unloader.sv
// Captures a wide register value and drains it LSB-chunk first
// as CHUNK-bit beats over a valid/ready stream.
module reg_unloader #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 32
) (
  input  logic          clk,
  input  logic          rst,
  reg_unloader_if.slave bus
);
  localparam int NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDXW =
    (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int SLOTS = 1 << IDXW;
  localparam int SW = SLOTS * CHUNK;
  localparam logic [IDXW-1:0] LAST_IDX =
    IDXW'(NUM_CHUNKS - 1);
  localparam logic ONE_BEAT = (NUM_CHUNKS == 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                       state;
  logic [SLOTS-1:0][CHUNK-1:0]  shadow;
  logic [IDXW-1:0]              idx;
  logic [IDXW-1:0]              idx_nxt;
  logic [SW-1:0]                snap_pad;
  logic                         accept;

  // Shadow is sized to a power-of-two slot count so idx
  // always indexes in range; unused slots stay zero.
  always_comb begin
    snap_pad = '0;
    snap_pad[WIDTH-1:0] = bus.snap_data;
  end

  assign idx_nxt = idx + IDXW'(1);

  // out_last is only ever set while in SEND
  assign accept = bus.snap_req &
    ((state == IDLE) | (bus.out_ready & bus.out_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shadow        <= '0;
      idx           <= '0;
      bus.snap_ack  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.snap_ack <= accept;
      if (accept) begin
        state         <= SEND;
        shadow        <= snap_pad;
        idx           <= '0;
        bus.busy      <= 1'b1;
        bus.out_valid <= 1'b1;
        bus.out_data  <= snap_pad[CHUNK-1:0];
        bus.out_last  <= ONE_BEAT;
      end else begin
        unique case (state)
          IDLE: begin
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
          end
          SEND: begin
            if (bus.out_ready) begin
              if (bus.out_last) begin
                state         <= IDLE;
                bus.busy      <= 1'b0;
                bus.out_valid <= 1'b0;
                bus.out_data  <= '0;
                bus.out_last  <= 1'b0;
              end else begin
                idx          <= idx_nxt;
                bus.out_data <= shadow[idx_nxt];
                bus.out_last <= (idx_nxt == LAST_IDX);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
